// File: rtl/cam_capture.sv
// Camera stream capture: pairs PCLK-domain bytes into 16-bit pixels, tracks X/Y and a
// linear frame-buffer address, and reports frame start/done pulses plus line/frame errors.
module cam_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter int unsigned AW       = 19
) (
  input  logic          PCLK,
  input  logic          RST_N,
  input  logic          CamHsync,
  input  logic          CamVsync,
  input  logic [7:0]    CamData,
  input  logic          CapEn,
  output logic [15:0]   PixData,
  output logic          PixValid,
  output logic [XW-1:0] PixX,
  output logic [YW-1:0] PixY,
  output logic [AW-1:0] PixAddr,
  output logic          FrameStart,
  output logic          FrameDone,
  output logic [7:0]    FrameCnt,
  output logic          ErrLine,
  output logic          ErrFrame
);

  localparam int unsigned LINE_BYTES = 2 * H_ACTIVE;
  localparam int unsigned BCW        = $clog2(LINE_BYTES + 2);
  localparam int unsigned LCW        = $clog2(V_ACTIVE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_WAIT_FALL,
    S_ACTIVE,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            d_hs_q, d_vs_q;
  logic [7:0]      d_data_q;
  logic            phase_q, phase_d;
  logic [7:0]      hi_q, hi_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [XW-1:0]   col_q, col_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   base_q, base_d;
  logic [LCW-1:0]  lines_q, lines_d;
  logic [15:0]     pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic [XW-1:0]   pix_x_q, pix_x_d;
  logic [YW-1:0]   pix_y_q, pix_y_d;
  logic [AW-1:0]   pix_addr_q, pix_addr_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            err_line_q, err_line_d;
  logic            err_frame_q, err_frame_d;

  // Input stage: every decision below uses these registered copies.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      d_hs_q   <= 1'b0;
      d_vs_q   <= 1'b0;
      d_data_q <= 8'h00;
    end else begin
      d_hs_q   <= CamHsync;
      d_vs_q   <= CamVsync;
      d_data_q <= CamData;
    end
  end

  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      phase_q       <= 1'b0;
      hi_q          <= 8'h00;
      bcnt_q        <= '0;
      col_q         <= '0;
      addr_q        <= '0;
      base_q        <= '0;
      lines_q       <= '0;
      pix_data_q    <= 16'h0000;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_addr_q    <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_cnt_q   <= 8'h00;
      err_line_q    <= 1'b0;
      err_frame_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      bcnt_q        <= bcnt_d;
      col_q         <= col_d;
      addr_q        <= addr_d;
      base_q        <= base_d;
      lines_q       <= lines_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_addr_q    <= pix_addr_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_cnt_q   <= frame_cnt_d;
      err_line_q    <= err_line_d;
      err_frame_q   <= err_frame_d;
    end
  end

  // col/addr/lines describe the next pixel; PixX/PixY/PixAddr latch them with PixData.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    bcnt_d        = bcnt_q;
    col_d         = col_q;
    addr_d        = addr_q;
    base_d        = base_q;
    lines_d       = lines_q;
    pix_data_d    = pix_data_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_addr_d    = pix_addr_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    err_line_d    = err_line_q;
    err_frame_d   = err_frame_q;

    case (state_q)
      S_IDLE: begin
        if (CapEn) state_d = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (d_vs_q) state_d = S_WAIT_FALL;
      end
      S_WAIT_FALL: begin
        if (!d_vs_q) begin
          state_d       = S_ACTIVE;
          frame_start_d = 1'b1;
          pix_x_d       = '0;
          pix_y_d       = '0;
          pix_addr_d    = '0;
          phase_d       = 1'b0;
          bcnt_d        = '0;
          col_d         = '0;
          addr_d        = '0;
          base_d        = '0;
          lines_d       = '0;
          err_line_d    = 1'b0;
          err_frame_d   = 1'b0;
        end
      end
      S_ACTIVE: begin
        if (d_hs_q) begin
          if (bcnt_q < BCW'(LINE_BYTES)) begin
            bcnt_d = bcnt_q + BCW'(1);
            if (!phase_q) begin
              hi_d    = d_data_q;
              phase_d = 1'b1;
            end else begin
              pix_data_d  = {hi_q, d_data_q};
              pix_valid_d = 1'b1;
              pix_x_d     = col_q;
              pix_y_d     = YW'(lines_q);
              pix_addr_d  = addr_q;
              col_d       = col_q + XW'(1);
              addr_d      = addr_q + AW'(1);
              phase_d     = 1'b0;
            end
          end else begin
            bcnt_d     = BCW'(LINE_BYTES + 1);
            err_line_d = 1'b1;
          end
        end else if (bcnt_q != '0) begin
          // End of line: snap the address to the next row base so short lines never skew.
          if (bcnt_q != BCW'(LINE_BYTES)) err_line_d = 1'b1;
          bcnt_d  = '0;
          phase_d = 1'b0;
          col_d   = '0;
          base_d  = base_q + AW'(H_ACTIVE);
          addr_d  = base_q + AW'(H_ACTIVE);
          lines_d = lines_q + LCW'(1);
          if (lines_d == LCW'(V_ACTIVE)) state_d = S_DONE;
        end
        if (d_vs_q) begin
          state_d = S_DONE;
          if (lines_d < LCW'(V_ACTIVE)) err_frame_d = 1'b1;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        frame_cnt_d  = frame_cnt_q + 8'd1;
        state_d      = CapEn ? S_WAIT_VS : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign PixData    = pix_data_q;
  assign PixValid   = pix_valid_q;
  assign PixX       = pix_x_q;
  assign PixY       = pix_y_q;
  assign PixAddr    = pix_addr_q;
  assign FrameStart = frame_start_q;
  assign FrameDone  = frame_done_q;
  assign FrameCnt   = frame_cnt_q;
  assign ErrLine    = err_line_q;
  assign ErrFrame   = err_frame_q;

endmodule

// File: doc/cam_capture.md
Name: cam_capture

Overview:
- Downstream consumer of the camera sync/data stream: PCLK-domain bytes with a line-valid Hsync (high = active bytes) and a Vsync that is high during vertical blanking.
- Pairs bytes into 16-bit pixels (first byte = MSB) and tracks pixel X/Y.
- Produces a linear frame-buffer write address and emits frame start/done pulses plus status flags.
- Sits between the camera (or its test-pattern model) and the frame-buffer write port.

Parameters:
- H_ACTIVE, 640, pixels captured per line (2*H_ACTIVE bytes)
- V_ACTIVE, 480, lines captured per frame
- XW, 10, PixX width
- YW, 9, PixY width
- AW, 19, PixAddr width

Ports:
- PCLK  in  1  camera pixel clock; all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- CamHsync  in  1  line valid, high during active bytes
- CamVsync  in  1  frame sync, high = vertical blank
- CamData  in  8  byte stream
- CapEn  in  1  capture enable (level)
- PixData  out  16  assembled pixel {byte0, byte1}
- PixValid  out  1  one-cycle strobe per pixel
- PixX  out  XW  column of PixData
- PixY  out  YW  row of PixData
- PixAddr  out  AW  PixY*H_ACTIVE+PixX, kept as a running counter (no multiplier)
- FrameStart  out  1  one-cycle pulse on capture start
- FrameDone  out  1  one-cycle pulse on capture end
- FrameCnt  out  8  completed frames, wraps 255->0
- ErrLine  out  1  sticky: a line had a byte count other than 2*H_ACTIVE
- ErrFrame  out  1  sticky: Vsync rose before V_ACTIVE lines were captured

Behaviour:
- Reset: all outputs 0, state IDLE, byte phase 0. Sticky errors clear only on reset or on FrameStart.
- Input stage: CamHsync, CamVsync and CamData registered once (d_hs, d_vs, d_data). All decisions use the registered copies.
- States and transitions:
  - IDLE: go to WAIT_VS when CapEn=1.
  - WAIT_VS: go to WAIT_FALL when d_vs=1.
  - WAIT_FALL: on d_vs 1->0, go to ACTIVE. At that transition: pulse FrameStart; set PixY=0, PixX=0, PixAddr=0, phase=0; clear ErrLine/ErrFrame.
  - ACTIVE: capture (rules below).
  - DONE: pulse FrameDone for one cycle and increment FrameCnt. Next state is WAIT_VS if CapEn=1, else IDLE.
- Byte pairing (ACTIVE, d_hs=1):
  - phase=0: latch d_data as the high byte.
  - phase=1: on the next edge, PixData={hi, d_data} and PixValid=1.
  - phase toggles on each byte.
  - Latency: the second byte is on CamData before edge n, so PixValid is high after edge n+1 (2 PCLK).
- Pixel counters: after each PixValid, PixX and PixAddr increment. PixX/PixY are the coordinates of the pixel currently on PixData.
- Over-length line: bytes beyond 2*H_ACTIVE in a line are dropped (no PixValid) and set ErrLine.
- End of line: on d_hs 1->0 in ACTIVE:
  - If the line byte count != 2*H_ACTIVE, set ErrLine. An odd trailing byte is discarded.
  - phase=0; PixX=0; PixY increments.
  - PixAddr is rounded to (PixY+1)*H_ACTIVE, so short lines never shift later rows.
- Lines while Vsync high: lines arriving in IDLE/WAIT_VS/WAIT_FALL are ignored, with no PixValid.
- Frame completion:
  - After the V_ACTIVE-th line ends, go to DONE. Further lines are ignored until the next Vsync cycle.
  - If d_vs rises in ACTIVE first, set ErrFrame and go to DONE.
- CapEn low mid-frame: the current frame completes normally. CapEn is only sampled in IDLE and DONE.
- Reset mid-frame: immediate clear. The partial frame is never resumed; capture waits for a full Vsync high->low.
- Simultaneous d_hs fall and d_vs rise: end-of-line processing happens first, in the same cycle; the frame then ends (ErrFrame if the line count is still < V_ACTIVE).

Test Plan:
- Stream source: the team's camera test-pattern model (1568 PCLK/line, Hsync high for 1280 bytes, Vsync high lines 0-2, 510 lines), CapEn=1.
  - Expect exactly 640 PixValid per line, 480 lines, FrameDone once per frame, ErrLine=ErrFrame=0, FrameCnt=1 after the first frame.
- Pixel content on the first captured line (model line 3):
  - pixel 0 = 0x1212; pixel 4 = 0x0303; last pixel (639) = 0x0303.
  - PixAddr goes 0..639; PixY=1 begins at PixAddr=640.
- Short line: truncate one line's Hsync to 1001 bytes.
  - Expect 500 pixels on that line, ErrLine=1.
  - The next line's first PixAddr is still row*640.
- Early Vsync: force Vsync high after 100 lines.
  - Expect ErrFrame=1, FrameDone pulse, PixY max 99.
  - Next frame captures normally; ErrFrame clears at FrameStart.
- Reset asserted mid-line 200: all outputs 0 immediately.
  - After release, no PixValid until the next Vsync fall.
  - FrameStart then PixData 0x1212 at (0,0).
- CapEn dropped mid-frame: the frame completes (480 lines, FrameDone) and the FSM goes to IDLE. No FrameStart on the next Vsync fall.
